fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the single-cycle core. Owns the program counter register and drives the instruction-memory request/response handshake. Holds each fetched instruction stable while the core executes it, then loads the next-instruction address computed by the next-PC logic. Detects response timeouts and misaligned fetch addresses and flags them.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_timeout_ctr.sv | 36 +++
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC          : default program counter after reset (text segment base)
//   fetch_state_t     : fetch sequencer states
//   is_word_aligned() : true when an address sits on a 4-byte boundary
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    HOLD,
    ERR
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus.
//   imem_req    : fetch request (master -> memory)
//   imem_addr   : fetch address (master -> memory)
//   imem_gnt    : request accepted this cycle (memory -> master)
//   imem_rvalid : response data valid (memory -> master)
//   imem_rdata  : response instruction word (memory -> master)
interface fetch_ctrl_if
  import cpu_pkg::*;
  ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Response timeout counter for the fetch sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to zero
//   enable     : count one waiting cycle
//   expired    : count has reached MAX_WAIT-1, i.e. this is the last cycle
//                a response may still arrive without a fault
// The count saturates at MAX_WAIT and never wraps.
module fetch_timeout_ctr #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] SAT_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != SAT_CNT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the single-cycle core.
// Owns the PC, issues one fetch per instruction over the imem bus, holds the
// fetched word while the core executes it, then loads the next-PC address.
// Misaligned fetch addresses and response timeouts park the block in a
// sticky error state that only rst_n clears.
//   clk, rst_n  : clock, asynchronous active-low reset
//   imem        : instruction-memory bus (master side)
//   ins         : current instruction, stable while ins_valid
//   ins_valid   : ins is under execution
//   iaddr       : address of ins (current PC)
//   npc_valid   : core finished ins, npc_addr is valid
//   npc_addr    : next instruction address
//   stall       : core stall, blocks the PC update
//   retire_cnt  : retired instruction count (wraps)
//   fetch_err   : sticky fault flag
//   err_addr    : PC captured when the fault occurred
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         ins,
  output logic                ins_valid,
  output logic [31:0]         iaddr,
  input  logic                npc_valid,
  input  logic [31:0]         npc_addr,
  input  logic                stall,
  output logic [31:0]         retire_cnt,
  output logic                fetch_err,
  output logic [31:0]         err_addr
);

  import cpu_pkg::*;

  fetch_state_t state, state_nxt;
  logic [XLEN-1:0] pc;
  logic            tmo_clear;
  logic            tmo_en;
  logic            tmo_expired;
  logic            retire;

  fetch_timeout_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    ins_valid     = 1'b0;
    fetch_err     = 1'b0;
    tmo_clear     = 1'b1;
    tmo_en        = 1'b0;
    retire        = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // A misaligned PC never reaches the bus.
        if (!is_word_aligned(pc)) begin
          state_nxt = ERR;
        end else begin
          imem.imem_req = 1'b1;
          if (imem.imem_gnt) state_nxt = RESP;
        end
      end
      RESP: begin
        tmo_clear = 1'b0;
        tmo_en    = !imem.imem_rvalid;
        // A response in the limit cycle still counts as on time.
        if (imem.imem_rvalid)   state_nxt = HOLD;
        else if (tmo_expired)   state_nxt = ERR;
      end
      HOLD: begin
        ins_valid = 1'b1;
        retire    = npc_valid && !stall;
        if (retire) state_nxt = REQ;
      end
      ERR: fetch_err = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ins        <= '0;
      retire_cnt <= '0;
      err_addr   <= '0;
    end else begin
      if ((state == REQ) && !is_word_aligned(pc)) begin
        err_addr <= pc;
      end
      if (state == RESP) begin
        if (imem.imem_rvalid)  ins      <= imem.imem_rdata;
        else if (tmo_expired)  err_addr <= pc;
      end
      if (retire) begin
        pc         <= npc_addr;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  assign imem.imem_addr = pc;
  assign iaddr          = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int          MAX_WAIT = 15;
  localparam logic [31:0] RST_PC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] iaddr;
  logic        npc_valid;
  logic [31:0] npc_addr;
  logic        stall;
  logic [31:0] retire_cnt;
  logic        fetch_err;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (RST_PC),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .iaddr      (iaddr),
    .npc_valid  (npc_valid),
    .npc_addr   (npc_addr),
    .stall      (stall),
    .retire_cnt (retire_cnt),
    .fetch_err  (fetch_err),
    .err_addr   (err_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference view of the architectural state: what the core should see.
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;
  logic [31:0] exp_retire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    npc_valid       = 1'b0;
    npc_addr        = $urandom;
    stall           = 1'b0;
  endtask

  task automatic reset_dut();
    quiet_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_req",     32'(bus.imem_req), 32'd0);
    chk("rst_addr",    bus.imem_addr,     RST_PC);
    chk("rst_ins",     ins,               32'd0);
    chk("rst_valid",   32'(ins_valid),    32'd0);
    chk("rst_retire",  retire_cnt,        32'd0);
    chk("rst_err",     32'(fetch_err),    32'd0);
    chk("rst_erraddr", err_addr,          32'd0);
    rst_n      = 1'b1;
    exp_pc     = RST_PC;
    exp_ins    = '0;
    exp_retire = '0;
    tick();
    chk("first_req",  32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr,     RST_PC);
  endtask

  // One fetch: grant after gd cycles, response after rd waiting cycles.
  task automatic fetch(input int gd, input int rd, input logic [31:0] data);
    for (int i = 0; i < gd; i++) begin
      chk("req_wait", 32'(bus.imem_req), 32'd1);
      chk("req_addr", bus.imem_addr,     exp_pc);
      bus.imem_rvalid = 1'($urandom);
      tick();
    end
    bus.imem_rvalid = 1'b0;
    chk("req_gnt_cyc", 32'(bus.imem_req), 32'd1);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      chk("resp_valid", 32'(ins_valid),    32'd0);
      chk("resp_err",   32'(fetch_err),    32'd0);
      chk("resp_req",   32'(bus.imem_req), 32'd0);
      bus.imem_gnt = 1'($urandom);
      npc_valid    = 1'($urandom);
      tick();
    end
    bus.imem_gnt    = 1'b0;
    npc_valid       = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    exp_ins = data;
    chk("hold_valid", 32'(ins_valid), 32'd1);
    chk("hold_ins",   ins,            exp_ins);
    chk("hold_iaddr", iaddr,          exp_pc);
    chk("hold_err",   32'(fetch_err), 32'd0);
  endtask

  // Hold for ns stalled cycles (npc offers ignored), then retire to npc.
  task automatic hold_retire(input int ns, input logic [31:0] npc);
    for (int s = 0; s < ns; s++) begin
      stall           = 1'b1;
      npc_valid       = 1'($urandom);
      npc_addr        = $urandom;
      bus.imem_rvalid = 1'($urandom);
      tick();
      chk("stall_valid",  32'(ins_valid), 32'd1);
      chk("stall_ins",    ins,            exp_ins);
      chk("stall_iaddr",  iaddr,          exp_pc);
      chk("stall_retire", retire_cnt,     exp_retire);
    end
    stall           = 1'b0;
    bus.imem_rvalid = 1'b0;
    npc_valid       = 1'b1;
    npc_addr        = npc;
    tick();
    npc_valid = 1'b0;
    exp_pc     = npc;
    exp_retire = exp_retire + 1;
    chk("ret_addr",   bus.imem_addr,     exp_pc);
    chk("ret_iaddr",  iaddr,             exp_pc);
    chk("ret_count",  retire_cnt,        exp_retire);
    chk("ret_valid",  32'(ins_valid),    32'd0);
    chk("ret_req",    32'(bus.imem_req), 32'(npc[1:0] == 2'b00));
  endtask

  logic [31:0] rnd;

  initial begin
    reset_dut();

    // Basic fetch and retire.
    fetch(0, 3, 32'h2002_0005);
    chk("basic_iaddr", iaddr, 32'h0000_3000);
    hold_retire(0, 32'h0000_3004);
    chk("basic_retire", retire_cnt, 32'd1);

    // Stall priority over npc_valid.
    fetch(1, 0, 32'h1234_5678);
    for (int s = 0; s < 4; s++) begin
      stall     = 1'b1;
      npc_valid = 1'b1;
      npc_addr  = 32'h0000_3010;
      tick();
      chk("stall4_pc",     iaddr,          32'h0000_3004);
      chk("stall4_valid",  32'(ins_valid), 32'd1);
      chk("stall4_retire", retire_cnt,     32'd1);
    end
    hold_retire(0, 32'h0000_3010);

    // Response in the last allowed cycle is captured, no fault.
    fetch(0, MAX_WAIT - 1, 32'hCAFE_0001);
    hold_retire(1, 32'h0000_3014);

    // Randomized fetch/retire traffic.
    for (int n = 0; n < 25; n++) begin
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, MAX_WAIT - 1)), $urandom);
      rnd = $urandom;
      rnd[1:0] = 2'b00;
      hold_retire(int'($urandom_range(0, 3)), rnd);
    end

    // Response timeout.
    chk("tmo_req", 32'(bus.imem_req), 32'd1);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      chk("tmo_early", 32'(fetch_err), 32'd0);
      tick();
    end
    chk("tmo_err",     32'(fetch_err),    32'd1);
    chk("tmo_erraddr", err_addr,          exp_pc);
    chk("tmo_req0",    32'(bus.imem_req), 32'd0);
    chk("tmo_valid",   32'(ins_valid),    32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom;
      bus.imem_gnt    = 1'b1;
      npc_valid       = 1'b1;
      tick();
      chk("err_sticky",  32'(fetch_err),    32'd1);
      chk("err_valid",   32'(ins_valid),    32'd0);
      chk("err_req",     32'(bus.imem_req), 32'd0);
      chk("err_pc",      iaddr,             exp_pc);
      chk("err_retire",  retire_cnt,        exp_retire);
      chk("err_addr_hd", err_addr,          exp_pc);
    end

    // Misaligned next-PC.
    reset_dut();
    fetch(0, 1, 32'h0000_0013);
    hold_retire(0, 32'h0000_3006);
    tick();
    chk("mis_err",     32'(fetch_err),    32'd1);
    chk("mis_erraddr", err_addr,          32'h0000_3006);
    chk("mis_req",     32'(bus.imem_req), 32'd0);

    // Reset in the middle of a response wait, followed by a stale response.
    reset_dut();
    fetch(2, 1, 32'h0BAD_F00D);
    hold_retire(0, 32'h0000_3008);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_ins",   ins,               32'd0);
    chk("mid_valid", 32'(ins_valid),    32'd0);
    chk("mid_pc",    iaddr,             RST_PC);
    chk("mid_ret",   retire_cnt,        32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc     = RST_PC;
    exp_ins    = '0;
    exp_retire = '0;
    tick();
    chk("late_req",   32'(bus.imem_req), 32'd1);
    chk("late_addr",  bus.imem_addr,     RST_PC);
    chk("late_ins",   ins,               32'd0);
    chk("late_valid", 32'(ins_valid),    32'd0);
    tick();
    chk("late_ins2",  ins,               32'd0);
    chk("late_req2",  32'(bus.imem_req), 32'd1);
    bus.imem_rvalid = 1'b0;
    fetch(0, 0, 32'h0000_0073);
    hold_retire(2, 32'h0000_3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
